// File: rtl/decap_packet.sv
// Aurora RX decapsulator: strips the 9-bit per-beat header and reassembles 19 beats into one DFX word.
// Optional build macro DECAP_HDR_CHECK_EN enables per-beat header checking against the latched header.
module decap_packet #(
    parameter int DATA_WIDTH             = 1024,
    parameter int ADDR_WIDTH             = 10,
    parameter int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH,
    parameter int RECOGNIZE_ROUTER_WIDTH = 2,
    parameter int NUMBER_PACKET          = 19,
    parameter int TTL_WIDTH              = $clog2(3),
    parameter int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + $clog2(NUMBER_PACKET) + TTL_WIDTH,
    parameter int AURORA_DATA_WIDTH      = 64,
    parameter int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [AURORA_DATA_WIDTH-1:0] data_out_port_0,
    input  logic                         data_decap_valid,
    output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
    output logic [HEADER_WIDTH-1:0]      header_pkt_recv,
    output logic                         data_dfx_valid,
    input  logic                         data_dfx_ready,
    output logic                         busy,
    output logic                         hdr_err,
    output logic                         overflow_err
);

    localparam int CNT_W = $clog2(NUMBER_PACKET);
    localparam int OFF_W = $clog2(DATA_DFX_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUMBER_PACKET - 1);
    localparam logic [DATA_DFX_WIDTH-1:0] SLOT_MASK =
        {{(DATA_DFX_WIDTH-PAYLOAD_WIDTH){1'b0}}, {PAYLOAD_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DATA_DFX_WIDTH-1:0]   data_q, data_d;
    logic [HEADER_WIDTH-1:0]     hdr_q, hdr_d;
    logic                        valid_q, busy_q;
    logic                        hdr_err_q, hdr_err_d;
    logic                        ovf_err_q, ovf_err_d;

    logic [HEADER_WIDTH-1:0]     beat_hdr_s;
    logic [PAYLOAD_WIDTH-1:0]    beat_pay_s;
    logic                        hdr_mismatch_s;
    logic                        wr_en_s;
    logic [CNT_W-1:0]            wr_idx_s;
    logic [OFF_W-1:0]            slot_off_s;
    logic [DATA_DFX_WIDTH-1:0]   slot_mask_s;
    logic [DATA_DFX_WIDTH-1:0]   pay_shift_s;

    assign beat_hdr_s = data_out_port_0[HEADER_WIDTH-1:0];
    assign beat_pay_s = data_out_port_0[AURORA_DATA_WIDTH-1:HEADER_WIDTH];

`ifdef DECAP_HDR_CHECK_EN
    assign hdr_mismatch_s = (beat_hdr_s != hdr_q);
`else
    assign hdr_mismatch_s = 1'b0;
`endif

    // Next-state, beat counter, header latch and error pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        wr_en_s   = 1'b0;
        wr_idx_s  = cnt_q;
        hdr_err_d = 1'b0;
        ovf_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_decap_valid) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = CNT_ZERO;
                    hdr_d    = beat_hdr_s;
                    cnt_d    = CNT_ONE;
                    state_d  = ST_COLLECT;
                end else begin
                    cnt_d    = CNT_ZERO;
                end
            end
            ST_COLLECT: begin
                if (data_decap_valid) begin
                    if (hdr_mismatch_s) begin
                        // Partial word is abandoned; the offending beat starts a new one.
                        wr_en_s   = 1'b1;
                        wr_idx_s  = CNT_ZERO;
                        hdr_d     = beat_hdr_s;
                        cnt_d     = CNT_ONE;
                        hdr_err_d = 1'b1;
                    end else begin
                        wr_en_s  = 1'b1;
                        wr_idx_s = cnt_q;
                        if (cnt_q >= LAST_IDX) begin
                            cnt_d   = CNT_ZERO;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d   = cnt_q + CNT_ONE;
                        end
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (data_dfx_ready) begin
                    if (data_decap_valid) begin
                        wr_en_s  = 1'b1;
                        wr_idx_s = CNT_ZERO;
                        hdr_d    = beat_hdr_s;
                        cnt_d    = CNT_ONE;
                        state_d  = ST_COLLECT;
                    end else begin
                        cnt_d    = CNT_ZERO;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    // No backpressure toward Aurora, so a beat arriving now is lost.
                    ovf_err_d = data_decap_valid;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Slot write: the shifted mask naturally clips the last slot at the word's top bit.
    always_comb begin
        slot_off_s  = OFF_W'(wr_idx_s) * OFF_W'(PAYLOAD_WIDTH);
        slot_mask_s = SLOT_MASK << slot_off_s;
        pay_shift_s = {{(DATA_DFX_WIDTH-PAYLOAD_WIDTH){1'b0}}, beat_pay_s} << slot_off_s;
        if (wr_en_s) begin
            data_d = (data_q & ~slot_mask_s) | (pay_shift_s & slot_mask_s);
        end else begin
            data_d = data_q;
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            data_q    <= {DATA_DFX_WIDTH{1'b0}};
            hdr_q     <= {HEADER_WIDTH{1'b0}};
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            hdr_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            hdr_q     <= hdr_d;
            valid_q   <= (state_d == ST_HOLD);
            busy_q    <= (state_d != ST_IDLE);
            hdr_err_q <= hdr_err_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    assign data_dfx_recv   = data_q;
    assign header_pkt_recv = hdr_q;
    assign data_dfx_valid  = valid_q;
    assign busy            = busy_q;
    assign hdr_err         = hdr_err_q;
    assign overflow_err    = ovf_err_q;

endmodule
